// File: rtl/wb_uart_tracer_if.sv
// rtl/wb_uart_tracer_if.sv - writeback snoop bus seen by the UART tracer.
// Carries PC_WB as well when WB_TRACE_PC_EN is defined.
interface wb_uart_tracer_if;
  logic        WB_EN;
  logic [4:0]  dest;
  logic [31:0] writeVal;
`ifdef WB_TRACE_PC_EN
  logic [31:0] PC_WB;

  modport master (output WB_EN, dest, writeVal, PC_WB);
  modport slave  (input  WB_EN, dest, writeVal, PC_WB);
`else
  modport master (output WB_EN, dest, writeVal);
  modport slave  (input  WB_EN, dest, writeVal);
`endif
endinterface

// File: rtl/wb_uart_tracer.sv
// rtl/wb_uart_tracer.sv - buffers register writebacks and sends them as 8N1 UART packets.
// Define WB_TRACE_PC_EN to append PC_WB to every packet (9 bytes, marker 3'b110).
module wb_uart_tracer #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trace_en,
  wb_uart_tracer_if.slave             wb,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

`ifdef WB_TRACE_PC_EN
  localparam int         ENTRY_W   = 69;
  localparam int         NUM_BYTES = 9;
  localparam logic [2:0] MARKER    = 3'b110;
`else
  localparam int         ENTRY_W   = 37;
  localparam int         NUM_BYTES = 5;
  localparam logic [2:0] MARKER    = 3'b101;
`endif
  localparam int PKT_W = NUM_BYTES * 8;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [3:0]         byte_idx_q, byte_idx_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic               tx_q, tx_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];

  logic               capture, full, push, pop;
  logic               bit_done, last_byte;
  logic [7:0]         cur_byte;
  logic [ENTRY_W-1:0] entry;

`ifdef WB_TRACE_PC_EN
  assign entry = {wb.dest, wb.writeVal, wb.PC_WB};
`else
  assign entry = {wb.dest, wb.writeVal};
`endif

  assign capture   = trace_en && wb.WB_EN && (wb.dest != 5'd0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign bit_done  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx_q == 4'(NUM_BYTES - 1));
  // The byte on the wire is always the top of pkt_q; it shifts up after each stop bit.
  assign cur_byte  = pkt_q[PKT_W-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      pkt_q      <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      pkt_q      <= pkt_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_START;
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA:  if (bit_done && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_done) state_d = last_byte ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered, so the line trails the state by one clock.
  always_comb begin
    tx_d = 1'b1;
    pop  = 1'b0;
    unique case (state_q)
      S_IDLE:  pop  = (count_q != '0);
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx_q];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    clk_cnt_d  = (state_q == S_IDLE || bit_done) ? '0 : clk_cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    pkt_d      = pkt_q;
    if (state_q == S_START) begin
      bit_idx_d = '0;
    end
    if (state_q == S_DATA && bit_done) begin
      bit_idx_d = bit_idx_q + 3'd1;
    end
    if (pop) begin
      pkt_d      = {MARKER, mem_q[rd_ptr_q]};
      byte_idx_d = '0;
    end
    if (state_q == S_STOP && bit_done && !last_byte) begin
      pkt_d      = pkt_q << 8;
      byte_idx_d = byte_idx_q + 4'd1;
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    push       = capture && (!full || pop);
    overflow_d = overflow_q || (capture && !push);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry;
    end
  end

  assign tx         = tx_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: doc/wb_uart_tracer.md
Name: wb_uart_tracer

Overview:
Transmit-side companion to the board's UART receive pin. It snoops the writeback bus (WB_EN, dest, writeVal) that feeds regFile and buffers each architectural register write in a small FIFO. Buffered writes are serialized as 8N1 frames on UART_TXD, so a host can log the MIPS pipeline's retired results. It is instantiated at board top level and clocked from CLOCK_50.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 115200, UART bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per UART bit; must be ≥2
FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2

Ports:
clk  in  1  system clock (CLOCK_50)
rst  in  1  synchronous, active-high reset (SW[0])
trace_en  in  1  capture enable; when 0, no new events are queued
WB_EN  in  1  writeback enable from MEM2WB
dest  in  5  writeback destination register
writeVal  in  32  writeback value (WB_result)
tx  out  1  UART serial out (UART_TXD); idle high
busy  out  1  high while FIFO is non-empty or a frame is in flight
overflow  out  1  sticky; an event was dropped because the FIFO was full
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0. FSM=IDLE, FIFO empty.
- Reset is honoured in any state. Reset mid-frame aborts the frame and drives tx=1 from the next cycle; the partial frame is not resumed.
- Capture condition: trace_en && WB_EN && dest!=0, sampled each rising edge. Writes to $zero are never traced.
- Push: the captured entry {dest, writeVal} is written on the same edge it is sampled.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and count stays the same.
  - Otherwise the event is dropped, overflow is set to 1 and stays set until rst.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count = pushes − pops and saturates at neither end; it must never exceed FIFO_DEPTH.
- Event packet is 5 bytes, sent in order:
  - B0 = {3'b101, dest}
  - B1 = writeVal[31:24], B2 = [23:16], B3 = [15:8], B4 = [7:0]
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head into the packet register, set byte_idx=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=byte[bit_idx]. After CLKS_PER_BIT cycles, increment bit_idx. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<4, increment byte_idx and go to START (no gap between bytes). Else go to IDLE.
- Latency: a push into an empty idle FIFO at edge N causes a pop at edge N+1; the start bit is on tx from edge N+2.
- Inter-packet spacing: exactly one idle clock (tx=1) between the STOP of B4 and the next packet's START when the FIFO is non-empty.
- Packet duration is 50·CLKS_PER_BIT cycles, or 90·CLKS_PER_BIT with the option below.
- busy = (fifo_count!=0) || (FSM!=IDLE).
- The FIFO does not back-pressure the pipeline; the pipeline is never stalled by this block.

Optional Feature:
WB_TRACE_PC_EN
- Defined:
  - Adds input PC_WB (32 bit), captured alongside dest/writeVal; FIFO entries become 69 bits.
  - The packet grows to 9 bytes: B5..B8 = PC_WB MSB first.
  - B0 marker becomes 3'b110.
  - The STOP-state byte_idx limit becomes 8.
- Undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Sim params CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10). Pulse WB_EN with dest=5, writeVal=32'hDEADBEEF -> tx emits bytes A5,DE,AD,BE,EF, each 100 cycles, start bit beginning 2 cycles after the push; busy falls 1 cycle after the final stop bit ends.
- WB_EN=1, dest=0, writeVal=32'h12345678 -> no push, fifo_count stays 0, tx stays 1. Same event with trace_en=0 -> also ignored.
- FIFO_DEPTH=8: 10 back-to-back writes, dest=1..10 -> the first write is popped almost immediately, 8 are buffered, the 10th is dropped, overflow=1. The host decodes dest 1..9 in order, each packet separated by exactly one idle cycle.
- FIFO full with the FSM entering IDLE (pop) in the same cycle as a new push -> push accepted, fifo_count stays 8, overflow stays 0.
- Assert rst during DATA of B2 -> tx=1 on the next cycle; fifo_count=0, overflow=0, busy=0. A subsequent event transmits a clean 5-byte packet.
- With WB_TRACE_PC_EN: dest=3, writeVal=32'h1, PC_WB=32'h40 -> bytes C3,00,00,00,01,00,00,00,40.
